// File: rtl/psum_drain_if.sv
// Control, memory read port and output stream bundle for psum_drain.
// The checksum signal exists only when PSUM_DRAIN_CHECKSUM_EN is defined.
interface psum_drain_if #(
  parameter int unsigned ROWS = 3
);
  logic                   start;
  logic [15:0]            count;
  logic                   busy;
  logic                   done;
  logic [0:ROWS-1][31:0]  psum_rd_addr;
  logic [0:ROWS-1][63:0]  psum_rd_dout;
  logic                   m_valid;
  logic                   m_ready;
  logic [63:0]            m_data;
  logic [7:0]             m_row;
  logic                   m_last;
`ifdef PSUM_DRAIN_CHECKSUM_EN
  logic [63:0]            checksum;
`endif

  // Drain engine side
  modport master (
    input  start, count, psum_rd_dout, m_ready,
    output busy, done, psum_rd_addr, m_valid, m_data, m_row, m_last
`ifdef PSUM_DRAIN_CHECKSUM_EN
    , output checksum
`endif
  );

  // Host / memory side
  modport slave (
    output start, count, psum_rd_dout, m_ready,
    input  busy, done, psum_rd_addr, m_valid, m_data, m_row, m_last
`ifdef PSUM_DRAIN_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/psum_drain.sv
// Partial-sum read-out engine: walks every row's psum memory and streams words out
// through a credit-controlled FIFO. Optional output checksum: PSUM_DRAIN_CHECKSUM_EN.
module psum_drain #(
  parameter int unsigned ROWS         = 3,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  psum_drain_if.master  bus
);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_e;

  typedef struct packed {
    logic             vld;
    logic             last;
    logic [ROW_W-1:0] row;
  } tag_t;

  typedef struct packed {
    logic        vld;
    logic        last;
    logic [7:0]  row;
    logic [63:0] data;
  } ent_t;

  state_e           state_q;
  logic [15:0]      count_q;
  logic [15:0]      word_q;
  logic [ROW_W-1:0] row_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] outst_q;
  logic [CNT_W-1:0] fcnt_q;
  logic [CNT_W-1:0] fcnt_d;
  logic [CNT_W-1:0] wr_idx;
  tag_t             pipe_q [READ_LATENCY+1];
  ent_t             fifo_q [FIFO_DEPTH];
  ent_t             fifo_d [FIFO_DEPTH];
  ent_t             push_ent;
  logic             issue;
  logic             wrap_w;
  logic             final_w;
  logic             pop;
  logic             push;

  // Credit covers reads in flight plus FIFO occupancy, so the FIFO cannot overflow
  always_comb begin
    pop     = fifo_q[0].vld && bus.m_ready;
    push    = pipe_q[READ_LATENCY].vld;
    issue   = (state_q == S_ISSUE) && (outst_q < CNT_W'(FIFO_DEPTH));
    wrap_w  = (word_q == count_q - 16'd1);
    final_w = wrap_w && (row_q == ROW_W'(ROWS - 1));

    push_ent      = '0;
    push_ent.vld  = push;
    push_ent.last = pipe_q[READ_LATENCY].last;
    push_ent.row  = 8'(pipe_q[READ_LATENCY].row);
    for (int r = 0; r < int'(ROWS); r++) begin
      if (ROW_W'(r) == pipe_q[READ_LATENCY].row) push_ent.data = bus.psum_rd_dout[r];
    end
  end

  // Shift-register FIFO: head always sits in entry 0 so the outputs come straight from flops
  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[FIFO_DEPTH-1] = '0;
    end
    wr_idx = pop ? (fcnt_q - CNT_W'(1)) : fcnt_q;
    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (CNT_W'(i) == wr_idx) fifo_d[i] = push_ent;
      end
    end
    fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      word_q  <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      outst_q <= '0;
      fcnt_q  <= '0;
      for (int i = 0; i <= int'(READ_LATENCY); i++) pipe_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            count_q <= bus.count;
            word_q  <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.count == 16'd0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_q <= 32'({word_q, 3'b000});
            if (wrap_w) begin
              word_q <= '0;
              if (final_w) state_q <= S_FLUSH;
              else         row_q   <= row_q + ROW_W'(1);
            end else begin
              word_q <= word_q + 16'd1;
            end
          end
        end
        S_FLUSH: begin
          // The last beat is the youngest entry, so its pop means everything has drained
          if (pop && fifo_q[0].last) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      pipe_q[0].vld  <= issue;
      pipe_q[0].last <= issue && final_w;
      pipe_q[0].row  <= row_q;
      for (int i = 1; i <= int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];

      fifo_q  <= fifo_d;
      fcnt_q  <= fcnt_d;
      outst_q <= outst_q + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.psum_rd_addr = {ROWS{addr_q}};
  assign bus.m_valid      = fifo_q[0].vld;
  assign bus.m_data       = fifo_q[0].data;
  assign bus.m_row        = fifo_q[0].row;
  assign bus.m_last       = fifo_q[0].last;

`ifdef PSUM_DRAIN_CHECKSUM_EN
  logic [63:0] csum_q;

  // Running sum of every accepted output word, wrapping modulo 2^64
  always_ff @(posedge clk) begin
    if (rst)                                csum_q <= '0;
    else if (state_q == S_IDLE && bus.start) csum_q <= '0;
    else if (pop)                           csum_q <= csum_q + fifo_q[0].data;
  end

  assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// Directed, table-driven bench for psum_drain with a one-cycle-latency memory model.
module tb_psum_drain;
  localparam int unsigned ROWS = 3;
  localparam int unsigned RL   = 1;
  localparam int unsigned FD   = 4;
  localparam int          BUDGET = 5000;

  logic clk = 1'b0;
  logic rst;
  logic mem_ones = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  psum_drain_if #(.ROWS(ROWS)) bus ();

  psum_drain #(
    .ROWS(ROWS),
    .READ_LATENCY(RL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Row r, word w holds {r, w}; optional all-ones fill for the wrap-around sum
  always @(posedge clk) begin
    for (int r = 0; r < int'(ROWS); r++)
      bus.psum_rd_dout[r] <= mem_ones ? 64'hFFFF_FFFF_FFFF_FFFF
                                      : {32'(r), 32'(bus.psum_rd_addr[r] >> 3)};
  end

  typedef struct {
    int cnt;        // words per row
    int mode;       // 0: ready high, 1: ready low cycles 4..20, 2: random ready
    int exp_first;  // cycle of first m_valid, -1 if none
    int exp_done;   // cycle of done, -1 if not fixed
    bit ones;       // all-ones memory contents
  } scn_t;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_busy"},    64'(bus.busy),    64'd0);
    check64({tag, "_done"},    64'(bus.done),    64'd0);
    check64({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check64({tag, "_m_data"},  bus.m_data,       64'd0);
    check64({tag, "_m_row"},   64'(bus.m_row),   64'd0);
    check64({tag, "_m_last"},  64'(bus.m_last),  64'd0);
    for (int r = 0; r < int'(ROWS); r++)
      check64({tag, "_addr"}, 64'(bus.psum_rd_addr[r]), 64'd0);
`ifdef PSUM_DRAIN_CHECKSUM_EN
    check64({tag, "_checksum"}, bus.checksum, 64'd0);
`endif
  endtask

  // Cycle n below means "just after the n-th rising edge", edge 0 accepting start
  task automatic start_drain(input int cnt);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.count = 16'(cnt);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_scn(input scn_t s);
    int n, beats, first_v, done_cyc, done_cnt, last_cyc, total, er, ew, div;
    logic [63:0] ed, esum;
    logic rdy;
    total = int'(ROWS) * s.cnt;
    div = (s.cnt > 0) ? s.cnt : 1;
    beats = 0; first_v = -1; done_cyc = -1; done_cnt = 0; last_cyc = -100; esum = '0;
    mem_ones = s.ones;
    bus.m_ready = 1'b1;
    start_drain(s.cnt);
    n = 0;
    check64("busy_after_start", 64'(bus.busy), 64'd1);
    while (n < BUDGET) begin
      if (s.mode == 1)      rdy = !(n >= 4 && n <= 20);
      else if (s.mode == 2) rdy = 1'($urandom_range(0, 1));
      else                  rdy = 1'b1;
      bus.m_ready = rdy;
      if (s.cnt == 0) check64("addr_stays_zero", 64'(bus.psum_rd_addr[0]), 64'd0);
      if (bus.m_valid && first_v < 0) first_v = n;
      if (bus.m_valid && rdy) begin
        er = beats / div;
        ew = beats % div;
        ed = s.ones ? 64'hFFFF_FFFF_FFFF_FFFF : {32'(er), 32'(ew)};
        check64("beat_data", bus.m_data, ed);
        check64("beat_row",  64'(bus.m_row),  64'(er));
        check64("beat_last", 64'(bus.m_last), 64'(beats == total - 1));
        if (bus.m_last) last_cyc = n;
        esum += ed;
        beats++;
      end
      if (s.mode == 1 && (n == 8 || n == 20)) begin
        check64("stall_valid", 64'(bus.m_valid), 64'd1);
        check64("stall_hold",  bus.m_data, {32'd0, 32'd1});
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = n;
        check64("busy_at_done", 64'(bus.busy), 64'd0);
`ifdef PSUM_DRAIN_CHECKSUM_EN
        check64("checksum_at_done", bus.checksum, esum);
        if (s.ones && s.cnt == 2) check64("checksum_wrap", bus.checksum, 64'hFFFF_FFFF_FFFF_FFFA);
`endif
      end
      if (done_cnt > 0 && n >= done_cyc + 2) break;
      @(posedge clk); #1;
      n++;
    end
    check64("done_count", 64'(done_cnt), 64'd1);
    check64("beat_count", 64'(beats), 64'(total));
    check64("first_valid_cycle", 64'(first_v), 64'(s.exp_first));
    if (s.exp_done >= 0) check64("done_cycle", 64'(done_cyc), 64'(s.exp_done));
    if (total > 0) check64("done_after_last", 64'(done_cyc), 64'(last_cyc + 2));
  endtask

  initial begin
    scn_t tbl [6];
    scn_t again;
    tbl[0] = '{cnt: 0,   mode: 0, exp_first: -1, exp_done: 1,  ones: 1'b0};
    tbl[1] = '{cnt: 4,   mode: 0, exp_first: 3,  exp_done: 16, ones: 1'b0};
    tbl[2] = '{cnt: 4,   mode: 1, exp_first: 3,  exp_done: 33, ones: 1'b0};
    tbl[3] = '{cnt: 1,   mode: 0, exp_first: 3,  exp_done: 7,  ones: 1'b0};
    tbl[4] = '{cnt: 100, mode: 2, exp_first: 3,  exp_done: -1, ones: 1'b0};
    tbl[5] = '{cnt: 2,   mode: 0, exp_first: 3,  exp_done: 10, ones: 1'b1};
    again  = '{cnt: 2,   mode: 0, exp_first: 3,  exp_done: 10, ones: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    // Reset in the middle of a drain, while beat 5 is presented and reads are in flight
    mem_ones = 1'b0;
    bus.m_ready = 1'b1;
    start_drain(4);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check64("midreset_beat5_valid", 64'(bus.m_valid), 64'd1);
    check64("midreset_beat5_data",  bus.m_data, {32'd1, 32'd0});
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check64("post_reset_idle_valid", 64'(bus.m_valid), 64'd0);
    run_scn(again);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
